// File: rtl/lii_out_gearbox_if.sv
// Kernel-side stream bundle and LII phy output channel for lii_out_gearbox.
// The master modport is the gearbox; the slave modport is its environment.
interface lii_out_gearbox_if #(
  parameter int NOUT = 2,
  parameter int SW   = 8,
  parameter int PW   = 64
);
  logic [NOUT*SW-1:0] k_tdata;
  logic [NOUT-1:0]    k_tvalid;
  logic [NOUT-1:0]    k_tready;
  logic               flush;
  logic [PW-1:0]      lii_out_tdata;
  logic               lii_out_tvalid;
  logic               lii_out_tready;
  logic [7:0]         lii_out_src;
  logic [7:0]         lii_out_dst;
  logic [7:0]         lii_out_nbeats;
  logic               ce;
  logic [7:0]         dbg_idx;
  logic [7:0]         dbg_count;

  modport master (
    input  k_tdata, k_tvalid, flush, lii_out_tready,
    output k_tready, lii_out_tdata, lii_out_tvalid, lii_out_src, lii_out_dst,
           lii_out_nbeats, ce, dbg_idx, dbg_count
  );

  modport slave (
    output k_tdata, k_tvalid, flush, lii_out_tready,
    input  k_tready, lii_out_tdata, lii_out_tvalid, lii_out_src, lii_out_dst,
           lii_out_nbeats, ce, dbg_idx, dbg_count
  );
endinterface

// File: rtl/lii_out_gearbox.sv
// Packs NOUT lockstep kernel streams into PW-bit LII flits, buffers them in a
// show-ahead FIFO and drives one LII phy output channel plus the kernel clock enable.
module lii_out_gearbox #(
  parameter int         NOUT   = 2,
  parameter int         SW     = 8,
  parameter int         PW     = 64,
  parameter int         DEPTH  = 4,
  parameter logic [7:0] SRC_ID = 8'h00,
  parameter logic [7:0] DST_ID = 8'h01
) (
  input  logic aclk,
  input  logic arstn,
  lii_out_gearbox_if.master bus
);
  localparam int BW    = NOUT * SW;
  localparam int BEATS = PW / BW;
  localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  // Handshakes are valid/ready: a kernel beat transfers on a cycle where every
  // k_tvalid and k_tready are high; a flit transfers when lii_out_tvalid and
  // lii_out_tready are both high. tvalid never drops before its transfer.
  logic [PW-1:0] acc, flit;
  logic [IW-1:0] idx;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] mem_data [DEPTH];
  logic [7:0]    mem_nb   [DEPTH];
  logic          allv, space, last, can_accept, beat, push, pop;
  logic [7:0]    push_nb;

  assign allv       = &bus.k_tvalid;
  assign space      = (count < CW'(DEPTH));
  assign last       = (idx == IW'(BEATS - 1));
  assign can_accept = space | (~last & ~bus.flush);
  assign beat       = allv & can_accept;
  assign push       = (beat & (last | bus.flush)) |
                      (~beat & bus.flush & (idx != '0) & space);
  assign push_nb    = beat ? (8'(idx) + 8'd1) : 8'(idx);
  assign pop        = bus.lii_out_tvalid & bus.lii_out_tready;

  // acc is cleared on every push, so bits above the last written beat are already zero.
  always_comb begin
    flit = acc;
    for (int b = 0; b < BEATS; b++) begin
      if (beat && (idx == IW'(b))) flit[b*BW +: BW] = bus.k_tdata;
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      acc <= '0;
      idx <= '0;
    end else if (push) begin
      acc <= '0;
      idx <= '0;
    end else if (beat) begin
      acc <= flit;
      idx <= idx + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (push) begin
      mem_data[wr_ptr] <= flit;
      mem_nb[wr_ptr]   <= push_nb;
    end
  end

  // Payload is gated with tvalid so an empty or freshly reset FIFO shows zeros.
  assign bus.lii_out_tvalid = (count != '0);
  assign bus.lii_out_tdata  = bus.lii_out_tvalid ? mem_data[rd_ptr] : '0;
  assign bus.lii_out_nbeats = bus.lii_out_tvalid ? mem_nb[rd_ptr] : 8'd0;
  assign bus.lii_out_src    = SRC_ID;
  assign bus.lii_out_dst    = DST_ID;
  assign bus.k_tready       = {NOUT{beat}};
  assign bus.ce             = beat;
  assign bus.dbg_idx        = 8'(idx);
  assign bus.dbg_count      = 8'(count);
endmodule

// File: tb/tb_lii_out_gearbox.sv
// Directed bench for lii_out_gearbox with NOUT=2, SW=8, PW=64, DEPTH=4.
module tb_lii_out_gearbox;
  logic aclk = 1'b0;
  logic arstn = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [71:0] exp_q[$];

  always #5 aclk = ~aclk;

  lii_out_gearbox_if #(.NOUT(2), .SW(8), .PW(64)) bus ();

  lii_out_gearbox #(
    .NOUT(2), .SW(8), .PW(64), .DEPTH(4), .SRC_ID(8'h00), .DST_ID(8'h01)
  ) dut (
    .aclk  (aclk),
    .arstn (arstn),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic [15:0] d, input logic [1:0] v, input logic f);
    bus.k_tdata  = d;
    bus.k_tvalid = v;
    bus.flush    = f;
  endtask

  function automatic logic [15:0] bd(input int k);
    return {8'(8'hC0 + k), 8'(k)};
  endfunction

  function automatic logic [63:0] fd(input int f);
    logic [63:0] r;
    for (int b = 0; b < 4; b++) r[b*16 +: 16] = bd(4*f + b);
    return r;
  endfunction

  // Scoreboard: every flit leaving the channel must match the head of exp_q.
  always @(negedge aclk) begin
    if (arstn && bus.lii_out_tvalid && bus.lii_out_tready) begin
      if (exp_q.size() == 0) begin
        check("unexp_flit", 72'(exp_q.size()), 72'd1);
      end else begin
        logic [71:0] head;
        head = exp_q.pop_front();
        check("flit", {bus.lii_out_nbeats, bus.lii_out_tdata}, head);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(16'h0, 2'b00, 1'b0);
    bus.lii_out_tready = 1'b0;
    repeat (2) tick();
    @(negedge aclk);
    check("rst_tvalid", bus.lii_out_tvalid, 0);
    check("rst_tdata", bus.lii_out_tdata, 0);
    check("rst_nbeats", bus.lii_out_nbeats, 0);
    check("rst_tready", bus.k_tready, 0);
    check("rst_ce", bus.ce, 0);
    check("rst_count", bus.dbg_count, 0);
    check("rst_idx", bus.dbg_idx, 0);
    check("rst_src", bus.lii_out_src, 72'h00);
    check("rst_dst", bus.lii_out_dst, 72'h01);
    tick();
    arstn = 1'b1;

    // Full flit
    bus.lii_out_tready = 1'b1;
    exp_q.push_back({8'd4, 64'hA444_A333_A222_A111});
    for (int b = 0; b < 4; b++) begin
      drive({8'(8'hA1 + b), 8'(8'h11 * (b + 1))}, 2'b11, 1'b0);
      @(negedge aclk);
      check("t1_ce", bus.ce, 1);
      check("t1_rdy", bus.k_tready, 72'h3);
      tick();
    end
    drive(16'h0, 2'b00, 1'b0);
    @(negedge aclk);
    check("t1_tvalid", bus.lii_out_tvalid, 1);
    check("t1_nbeats", bus.lii_out_nbeats, 4);
    check("t1_ce_off", bus.ce, 0);
    tick();
    @(negedge aclk);
    check("t1_drained", bus.lii_out_tvalid, 0);

    // Skew: a lone valid stream never transfers
    for (int i = 0; i < 3; i++) begin
      drive(16'hB2B1, 2'b01, 1'b0);
      @(negedge aclk);
      check("t2_rdy", bus.k_tready, 0);
      check("t2_ce", bus.ce, 0);
      check("t2_idx", bus.dbg_idx, 0);
      tick();
    end
    drive(16'hB2B1, 2'b11, 1'b0);
    @(negedge aclk);
    check("t2_ce_both", bus.ce, 1);
    tick();
    drive(16'h0, 2'b00, 1'b1);
    exp_q.push_back({8'd1, 64'h0000_0000_0000_B2B1});
    @(negedge aclk);
    check("t2_idx1", bus.dbg_idx, 1);
    check("t2_flush_ce", bus.ce, 0);
    tick();
    drive(16'h0, 2'b00, 1'b0);
    @(negedge aclk);
    check("t2_idx0", bus.dbg_idx, 0);
    check("t2_tvalid", bus.lii_out_tvalid, 1);
    tick();

    // Flush partial, then flush together with a beat
    exp_q.push_back({8'd2, 64'h0000_0000_A222_A111});
    drive(16'hA111, 2'b11, 1'b0);
    tick();
    drive(16'hA222, 2'b11, 1'b0);
    tick();
    drive(16'h0, 2'b00, 1'b1);
    tick();
    drive(16'hA333, 2'b11, 1'b1);
    exp_q.push_back({8'd1, 64'h0000_0000_0000_A333});
    @(negedge aclk);
    check("t3_idx0", bus.dbg_idx, 0);
    check("t3_ce", bus.ce, 1);
    check("t3_nb2", bus.lii_out_nbeats, 2);
    tick();
    drive(16'h0, 2'b00, 1'b0);
    @(negedge aclk);
    check("t3_idx_after", bus.dbg_idx, 0);
    check("t3_nb1", bus.lii_out_nbeats, 1);
    tick();
    drive(16'h0, 2'b00, 1'b1);
    tick();
    tick();
    @(negedge aclk);
    check("t3_idle_cnt", bus.dbg_count, 0);
    check("t3_idle_tv", bus.lii_out_tvalid, 0);
    check("t3_idle_idx", bus.dbg_idx, 0);
    drive(16'h0, 2'b00, 1'b0);
    tick();

    // Backpressure and simultaneous push/pop at a full FIFO
    bus.lii_out_tready = 1'b0;
    for (int f = 0; f < 5; f++) exp_q.push_back({8'd4, fd(f)});
    for (int k = 0; k < 19; k++) begin
      drive(bd(k), 2'b11, 1'b0);
      @(negedge aclk);
      check("t4_ce", bus.ce, 1);
      tick();
    end
    drive(bd(19), 2'b11, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("t4_stall_ce", bus.ce, 0);
      check("t4_stall_rdy", bus.k_tready, 0);
      check("t4_count", bus.dbg_count, 4);
      check("t4_idx", bus.dbg_idx, 3);
      check("t4_hold", {bus.lii_out_nbeats, bus.lii_out_tdata}, {8'd4, fd(0)});
      tick();
    end
    bus.lii_out_tready = 1'b1;
    @(negedge aclk);
    check("t4_pop_cycle_ce", bus.ce, 0);
    tick();
    @(negedge aclk);
    check("t4_next_ce", bus.ce, 1);
    check("t4_next_cnt", bus.dbg_count, 3);
    tick();
    drive(16'h0, 2'b00, 1'b0);
    for (int i = 0; i < 30; i++) begin
      if (bus.dbg_count == 8'd0) break;
      tick();
    end
    check("t4_drain", bus.dbg_count, 0);

    // Reset mid-operation
    bus.lii_out_tready = 1'b0;
    for (int k = 0; k < 14; k++) begin
      drive(bd(40 + k), 2'b11, 1'b0);
      tick();
    end
    drive(16'h0, 2'b00, 1'b0);
    @(negedge aclk);
    check("t5_count3", bus.dbg_count, 3);
    check("t5_idx2", bus.dbg_idx, 2);
    @(posedge aclk);
    #1;
    arstn = 1'b0;
    #1;
    check("t5_rst_tvalid", bus.lii_out_tvalid, 0);
    check("t5_rst_count", bus.dbg_count, 0);
    check("t5_rst_idx", bus.dbg_idx, 0);
    check("t5_rst_tdata", bus.lii_out_tdata, 0);
    check("t5_rst_src", bus.lii_out_src, 72'h00);
    check("t5_rst_dst", bus.lii_out_dst, 72'h01);
    tick();
    arstn = 1'b1;
    bus.lii_out_tready = 1'b1;
    exp_q.push_back({8'd4, 64'hE4F4_E3F3_E2F2_E1F1});
    for (int b = 0; b < 4; b++) begin
      drive({8'(8'hE1 + b), 8'(8'hF1 + b)}, 2'b11, 1'b0);
      tick();
    end
    drive(16'h0, 2'b00, 1'b0);
    @(negedge aclk);
    check("t5_post_tvalid", bus.lii_out_tvalid, 1);
    for (int i = 0; i < 10; i++) begin
      if (bus.dbg_count == 8'd0) break;
      tick();
    end
    tick();
    check("t5_drain", bus.dbg_count, 0);
    check("t5_src", bus.lii_out_src, 72'h00);
    check("t5_dst", bus.lii_out_dst, 72'h01);
    check("sb_empty", 72'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
